stream_sink: RTL and testbench
==============================

# stream_sink

AXI-Stream capture buffer for the I2C verification environment. It receives byte streams from an I2C master or slave `m_axis_data_*` output and holds them in an 8-entry FIFO, so the bench can pop and compare bytes at its own pace. It also counts completed frames (`tlast` beats) and flags misuse of the pop port.

## Interface
Parameters:
- `DATA_WIDTH`, 8: stream byte width.
- `DEPTH`, 8: FIFO entries; must be a power of two.
- `ADDR_WIDTH`, 3: log2(`DEPTH`).

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `tdata`, input, `DATA_WIDTH`: stream data from the DUT.
- `tvalid`, input, 1: stream valid.
- `tready`, output, 1: stream ready.
- `tlast`, input, 1: end-of-frame marker, stored with each byte.
- `op_en`, input, 1: capture enable. When low, `tready` is forced to 0.
- `pop`, input, 1: read request from the bench.
- `Dout`, output, `DATA_WIDTH`: popped byte, registered.
- `Dout_last`, output, 1: `tlast` bit stored with the popped byte.
- `Dout_valid`, output, 1: one-cycle strobe marking a valid `Dout`.
- `buff_count`, output, `ADDR_WIDTH+1`: occupancy, range 0..`DEPTH`.
- `empty`, output, 1: high when `buff_count` is 0.
- `full`, output, 1: high when `buff_count` equals `DEPTH`.
- `frame_count`, output, 8: number of accepted `tlast` beats; wraps 255 -> 0.
- `underflow`, output, 1: sticky error flag, set by a pop while empty.

## Operation
- Storage: `DEPTH` entries, each `DATA_WIDTH`+1 bits wide ({last, data}).
- Pointers: write pointer and read pointer, each `ADDR_WIDTH` bits, wrapping naturally at `DEPTH`.
- Ready: `tready = op_en & ~full & ~rst`. It is combinational from registered state only; no dependency on `tvalid`.
- Push: happens when `tvalid & tready` at a rising edge.
  - Writes {`tlast`, `tdata`} at the write pointer, then increments the write pointer.
  - If `tlast` is 1, `frame_count` increments.
- Pop: happens when `pop & ~empty` at a rising edge.
  - Loads `Dout`/`Dout_last` from the read pointer, increments the read pointer, and sets `Dout_valid` to 1 for the next cycle.
  - Any other edge clears `Dout_valid`; `Dout` and `Dout_last` hold their last value.
- Underflow: `pop & empty` sets `underflow`. It stays set until `rst`. Nothing else changes.
- Occupancy:
  - `buff_count` goes +1 on push only, -1 on pop only, and is unchanged when both happen in the same cycle.
  - `empty` and `full` are registered and always consistent with `buff_count`.
- No internal state machine beyond the FIFO pointers and counters.

## Timing
- Reset values: `Dout`=0, `Dout_last`=0, `Dout_valid`=0, `buff_count`=0, `empty`=1, `full`=0, `frame_count`=0, `underflow`=0, both pointers 0.
  - `tready` is 0 while `rst` is high.
- Reset mid-transfer discards all stored bytes and counters on that edge. A `tvalid` beat presented with `rst` high is not accepted.
- Latency:
  - A pushed byte can be popped on the edge after it is written.
  - Push at edge N sets `empty` to 0 after edge N.
  - Pop at edge N+1 gives `Dout`/`Dout_valid` after edge N+1.
- Full:
  - `tready` is 0 while `full`, even if `pop` is high in the same cycle. There is no write-through bypass.
  - `tready` returns to 1 the cycle after the pop edge.
- Empty:
  - A push and a pop in the same cycle while empty: the push is accepted, the pop is rejected, and `underflow` is set.
  - The byte remains in the FIFO with count 1.
- Simultaneous push and pop while partially full: both are performed; count unchanged.
- Wrap-around: pointers roll over from `DEPTH`-1 to 0 with no gap or duplicate. Ordering is strictly FIFO.
- Dropping `op_en` mid-frame stalls the stream. Stored data and `frame_count` are unaffected.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, 0x44 with `tlast` on 0x44, then pop 4 times.
  - Expect `Dout` = 0x11, 0x22, 0x33, 0x44.
  - `Dout_last` is 1 only on 0x44; `frame_count`=1; `empty`=1 at the end.
- Hold `tvalid` high with `pop` low for 10 cycles.
  - Exactly 8 bytes are accepted; `full`=1, `buff_count`=8, `tready`=0.
  - One pop gives `tready`=1 on the next cycle and accepts byte 9.
- Pop while empty (with and without a simultaneous push).
  - `underflow`=1 and stays 1.
  - With the push: count goes 0 -> 1, and a later pop returns the pushed byte.
- Continuous push and pop at occupancy 4 for 20 cycles.
  - `buff_count` stays 4; the output sequence matches the input order across pointer wrap.
- Assert `rst` after pushing 5 bytes with 2 `tlast` beats.
  - All outputs return to their reset values on the next edge.
- `op_en` low with `tvalid` high.
  - `tready`=0 and no count change.
  - Raising `op_en` resumes acceptance in the same cycle.

Source files
------------

// File: rtl/stream_sink.sv
// AXI-Stream capture FIFO: stores {tlast, tdata} beats for later popping by the bench,
// counts accepted frames and latches a sticky underflow flag on pops while empty.
module stream_sink #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] tdata,
   input  logic                  tvalid,
   output logic                  tready,
   input  logic                  tlast,
   input  logic                  op_en,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] Dout,
   output logic                  Dout_last,
   output logic                  Dout_valid,
   output logic [ADDR_WIDTH:0]   buff_count,
   output logic                  empty,
   output logic                  full,
   output logic [7:0]            frame_count,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = ADDR_WIDTH'(DEPTH) == '0 ?
                                             (ADDR_WIDTH+1)'(DEPTH) : (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  empty_q, empty_d;
   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_last_q, dout_last_d;
   logic                  dout_valid_q, dout_valid_d;
   logic [7:0]            frame_q, frame_d;
   logic                  uflow_q, uflow_d;
   logic                  push, pop_ok;

   // Ready depends only on registered state so it never combinationally follows tvalid.
   assign tready = op_en & ~full_q & ~rst;
   assign push   = tvalid & tready;
   assign pop_ok = pop & ~empty_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_last_d  = dout_last_q;
      dout_valid_d = 1'b0;
      frame_d      = frame_q;
      uflow_d      = uflow_q | (pop & empty_q);
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (tlast) frame_d = frame_q + 8'd1;
      end
      if (pop_ok) begin
         {dout_last_d, dout_d} = mem_q[rd_ptr_q];
         rd_ptr_d              = rd_ptr_q + 1'b1;
         dout_valid_d          = 1'b1;
      end
      if (push && !pop_ok)      count_d = count_q + 1'b1;
      else if (!push && pop_ok) count_d = count_q - 1'b1;
      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         dout_q       <= '0;
         dout_last_q  <= 1'b0;
         dout_valid_q <= 1'b0;
         frame_q      <= '0;
         uflow_q      <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         dout_q       <= dout_d;
         dout_last_q  <= dout_last_d;
         dout_valid_q <= dout_valid_d;
         frame_q      <= frame_d;
         uflow_q      <= uflow_d;
      end
   end

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {tlast, tdata};
   end

   assign Dout        = dout_q;
   assign Dout_last   = dout_last_q;
   assign Dout_valid  = dout_valid_q;
   assign buff_count  = count_q;
   assign empty       = empty_q;
   assign full        = full_q;
   assign frame_count = frame_q;
   assign underflow   = uflow_q;

endmodule

// File: tb/tb_stream_sink.sv
// Directed bench for stream_sink: one task per scenario, inline checks, one summary line.
module tb_stream_sink;
   logic       clk = 1'b0;
   logic       rst, tvalid, tlast, op_en, pop;
   logic [7:0] tdata;
   logic       tready, Dout_last, Dout_valid, empty, full, underflow;
   logic [7:0] Dout, frame_count;
   logic [3:0] buff_count;
   int checks = 0;
   int errors = 0;

   stream_sink #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .tdata(tdata), .tvalid(tvalid), .tready(tready),
      .tlast(tlast), .op_en(op_en), .pop(pop), .Dout(Dout), .Dout_last(Dout_last),
      .Dout_valid(Dout_valid), .buff_count(buff_count), .empty(empty), .full(full),
      .frame_count(frame_count), .underflow(underflow));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      tvalid = 1'b0; tlast = 1'b0; pop = 1'b0; tdata = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1; op_en = 1'b1; idle();
      step(); step();
      checks++; if (Dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", Dout); end
      checks++; if ({Dout_last, Dout_valid, empty, full, underflow} !== 5'b00100) begin errors++;
         $display("FAIL rst_flags got %b exp 00100", {Dout_last, Dout_valid, empty, full, underflow}); end
      checks++; if (buff_count !== 4'd0 || frame_count !== 8'd0) begin errors++;
         $display("FAIL rst_counts got %0d/%0d exp 0/0", buff_count, frame_count); end
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", tready); end
      rst = 1'b0; #1;
      checks++; if (tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got %b exp 1", tready); end
   endtask

   task automatic test_basic();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) begin
         tvalid = 1'b1; tdata = vals[i]; tlast = (i == 3);
         step();
         if (i == 0) begin
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_empty_after_push got %b exp 0", empty); end
         end
      end
      idle();
      checks++; if (buff_count !== 4'd4 || frame_count !== 8'd1) begin errors++;
         $display("FAIL basic_counts got %0d/%0d exp 4/1", buff_count, frame_count); end
      for (int i = 0; i < 4; i++) begin
         pop = 1'b1; step();
         checks++; if (Dout !== vals[i] || Dout_valid !== 1'b1 || Dout_last !== (i == 3)) begin errors++;
            $display("FAIL basic_pop%0d got %h v%b l%b exp %h v1 l%b", i, Dout, Dout_valid, Dout_last, vals[i], i == 3); end
      end
      pop = 1'b0; step();
      checks++; if (empty !== 1'b1 || Dout_valid !== 1'b0 || Dout !== 8'h44) begin errors++;
         $display("FAIL basic_end got e%b v%b d%h exp e1 v0 d44", empty, Dout_valid, Dout); end
   endtask

   task automatic test_full();
      logic [7:0] exp_b;
      for (int i = 0; i < 10; i++) begin
         tvalid = 1'b1; tdata = 8'hA0 + 8'(i); tlast = 1'b0; step();
      end
      checks++; if (buff_count !== 4'd8 || full !== 1'b1 || tready !== 1'b0) begin errors++;
         $display("FAIL full_state got c%0d f%b r%b exp c8 f1 r0", buff_count, full, tready); end
      tdata = 8'hB9; pop = 1'b1; step();
      checks++; if (Dout !== 8'hA0 || buff_count !== 4'd7 || tready !== 1'b1) begin errors++;
         $display("FAIL full_pop got d%h c%0d r%b exp dA0 c7 r1", Dout, buff_count, tready); end
      pop = 1'b0; step();
      checks++; if (buff_count !== 4'd8 || full !== 1'b1) begin errors++;
         $display("FAIL full_byte9 got c%0d f%b exp c8 f1", buff_count, full); end
      idle();
      for (int i = 1; i < 9; i++) begin
         exp_b = (i == 8) ? 8'hB9 : 8'hA0 + 8'(i);
         pop = 1'b1; step();
         checks++; if (Dout !== exp_b) begin errors++; $display("FAIL full_drain%0d got %h exp %h", i, Dout, exp_b); end
      end
      pop = 1'b0; step();
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++;
         $display("FAIL full_drained got e%b u%b exp e1 u0", empty, underflow); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         tvalid = 1'b1; tdata = 8'h30 + 8'(i); step();
      end
      for (int i = 0; i < 20; i++) begin
         tvalid = 1'b1; tdata = 8'h34 + 8'(i); pop = 1'b1; step();
         checks++; if (buff_count !== 4'd4 || Dout !== 8'h30 + 8'(i) || Dout_valid !== 1'b1) begin errors++;
            $display("FAIL b2b_%0d got c%0d d%h v%b exp c4 d%h v1", i, buff_count, Dout, Dout_valid, 8'h30 + 8'(i)); end
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         pop = 1'b1; step();
         checks++; if (Dout !== 8'h44 + 8'(i)) begin errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, Dout, 8'h44 + 8'(i)); end
      end
      pop = 1'b0; step();
   endtask

   task automatic test_underflow();
      pop = 1'b1; step();
      checks++; if (underflow !== 1'b1 || buff_count !== 4'd0 || Dout_valid !== 1'b0) begin errors++;
         $display("FAIL uf_pop got u%b c%0d v%b exp u1 c0 v0", underflow, buff_count, Dout_valid); end
      tvalid = 1'b1; tdata = 8'h5A; step();
      checks++; if (underflow !== 1'b1 || buff_count !== 4'd1 || empty !== 1'b0 || Dout_valid !== 1'b0) begin errors++;
         $display("FAIL uf_pushpop got u%b c%0d e%b v%b exp u1 c1 e0 v0", underflow, buff_count, empty, Dout_valid); end
      tvalid = 1'b0; step();
      checks++; if (Dout !== 8'h5A || Dout_valid !== 1'b1) begin errors++;
         $display("FAIL uf_readback got %h v%b exp 5A v1", Dout, Dout_valid); end
      pop = 1'b0; step();
      checks++; if (underflow !== 1'b1 || empty !== 1'b1) begin errors++;
         $display("FAIL uf_sticky got u%b e%b exp u1 e1", underflow, empty); end
   endtask

   task automatic test_reset_mid();
      rst = 1'b1; step(); rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tvalid = 1'b1; tdata = 8'hC0 + 8'(i); tlast = (i == 1 || i == 4); step();
      end
      idle(); pop = 1'b1; step(); pop = 1'b0;
      checks++; if (frame_count !== 8'd2 || buff_count !== 4'd4 || Dout !== 8'hC0) begin errors++;
         $display("FAIL rmid_pre got f%0d c%0d d%h exp f2 c4 dC0", frame_count, buff_count, Dout); end
      rst = 1'b1; tvalid = 1'b1; tdata = 8'hEE; tlast = 1'b1; pop = 1'b1; step();
      checks++; if (Dout !== 8'h00 || buff_count !== 4'd0 || frame_count !== 8'd0 || tready !== 1'b0
                   || {Dout_last, Dout_valid, empty, full, underflow} !== 5'b00100) begin errors++;
         $display("FAIL rmid_reset got d%h c%0d f%0d r%b flags %b", Dout, buff_count, frame_count, tready,
                  {Dout_last, Dout_valid, empty, full, underflow}); end
      idle(); rst = 1'b0; step();
   endtask

   task automatic test_op_en();
      op_en = 1'b0; tvalid = 1'b1; tdata = 8'h77; #1;
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL open_ready_low got %b exp 0", tready); end
      step(); step();
      checks++; if (buff_count !== 4'd0) begin errors++; $display("FAIL open_nocount got %0d exp 0", buff_count); end
      op_en = 1'b1; #1;
      checks++; if (tready !== 1'b1) begin errors++; $display("FAIL open_ready_high got %b exp 1", tready); end
      step();
      checks++; if (buff_count !== 4'd1) begin errors++; $display("FAIL open_accept got %0d exp 1", buff_count); end
      idle(); pop = 1'b1; step(); pop = 1'b0;
      checks++; if (Dout !== 8'h77 || Dout_valid !== 1'b1) begin errors++;
         $display("FAIL open_readback got %h v%b exp 77 v1", Dout, Dout_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      test_op_en();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
